// File: rtl/osc_mon_pkg.sv
`timescale 1ns/1ps
// osc_mon_pkg
// Shared definitions for the oscillator frequency monitor: the measurement
// FSM state type, the flush length that covers synchronizer latency, and the
// default values of the monitor parameters.
package osc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Cycles spent in FLUSH after enable, so strobes built from stale
  // synchronizer contents never reach a window.
  localparam int FLUSH_LEN   = 3;
  localparam int FLUSH_CNT_W = 2;

  localparam int DEF_WINDOW   = 4000;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_LO_LIMIT = 90;
  localparam int DEF_HI_LIMIT = 110;

endpackage

// File: rtl/osc_mon_sync.sv
`timescale 1ns/1ps
// osc_mon_sync
// Brings the oscillator under test into the CLK domain through a two-flop
// synchronizer, delays it by one more flop and flags synchronized 0->1
// transitions.
// Ports:
//   CLK      - reference clock
//   RSTN     - asynchronous active-low reset, clears all three flops
//   ASYNC_IN - oscillator clock, asynchronous to CLK
//   EDGE_STB - one-cycle strobe per synchronized rising edge
module osc_mon_sync (
  input  logic CLK,
  input  logic RSTN,
  input  logic ASYNC_IN,
  output logic EDGE_STB
);

  // bit 0: first sync stage, bit 1: second sync stage, bit 2: delay stage
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], ASYNC_IN};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign EDGE_STB = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/osc_freq_monitor.sv
`timescale 1ns/1ps
// osc_freq_monitor
// Counts rising edges of an oscillator under test over a fixed window of
// reference clocks and publishes the count together with range, stuck and
// overflow flags once per window.
// Ports:
//   CLK      - reference clock, the only clock of this block
//   RSTN     - asynchronous active-low reset
//   CFGCLK   - oscillator under test, asynchronous, at most f(CLK)/3
//   EN       - measurement enable (level); dropping it aborts the window
//   COUNT    - edge count of the last completed window (saturating)
//   VALID    - one-cycle pulse when COUNT and the flags update
//   IN_RANGE - last count within LO_LIMIT..HI_LIMIT and not saturated
//   STUCK    - last window saw no edges
//   OVF      - last window count saturated
module osc_freq_monitor
  import osc_mon_pkg::*;
#(
  parameter int WINDOW   = DEF_WINDOW,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LO_LIMIT = DEF_LO_LIMIT,
  parameter int HI_LIMIT = DEF_HI_LIMIT
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CFGCLK,
  input  logic             EN,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             IN_RANGE,
  output logic             STUCK,
  output logic             OVF
);

  localparam int                     WIN_W      = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]       WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX    = '1;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);
  localparam logic [31:0]            LO_U       = LO_LIMIT;
  localparam logic [31:0]            HI_U       = HI_LIMIT;

  logic edge_stb;

  osc_mon_sync u_sync (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .ASYNC_IN (CFGCLK),
    .EDGE_STB (edge_stb)
  );

  state_e                 state_q,    state_d;
  logic [FLUSH_CNT_W-1:0] flush_q,    flush_d;
  logic [WIN_W-1:0]       win_q,      win_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic                   cnt_ovf_q,  cnt_ovf_d;
  logic [CNT_W-1:0]       count_q,    count_d;
  logic                   valid_q,    valid_d;
  logic                   in_range_q, in_range_d;
  logic                   stuck_q,    stuck_d;
  logic                   ovf_q,      ovf_d;

  // Window total including this cycle's strobe; the last window cycle's
  // strobe must land in the published result.
  logic [CNT_W-1:0] sum_cnt;
  logic             sum_ovf;
  logic [31:0]      sum_ext;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    cnt_ovf_d  = cnt_ovf_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    stuck_d    = stuck_q;
    ovf_d      = ovf_q;

    sum_cnt = cnt_q;
    sum_ovf = cnt_ovf_q;
    if (edge_stb) begin
      if (cnt_q == CNT_MAX) begin
        sum_ovf = 1'b1;
      end else begin
        sum_cnt = cnt_q + CNT_W'(1);
      end
    end
    sum_ext = {{(32 - CNT_W){1'b0}}, sum_cnt};

    case (state_q)
      IDLE: begin
        flush_d   = '0;
        win_d     = '0;
        cnt_d     = '0;
        cnt_ovf_d = 1'b0;
        if (EN) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (flush_q == FLUSH_LAST) begin
          state_d   = MEASURE;
          flush_d   = '0;
          win_d     = '0;
          cnt_d     = '0;
          cnt_ovf_d = 1'b0;
        end else begin
          flush_d = flush_q + FLUSH_CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!EN) begin
          // Abort: published results stay as they are.
          state_d = IDLE;
        end else if (win_q == WIN_LAST) begin
          count_d    = sum_cnt;
          ovf_d      = sum_ovf;
          stuck_d    = (sum_cnt == '0);
          in_range_d = (sum_ext >= LO_U) && (sum_ext <= HI_U) && !sum_ovf;
          valid_d    = 1'b1;
          // Next window starts immediately, no gap cycle.
          win_d      = '0;
          cnt_d      = '0;
          cnt_ovf_d  = 1'b0;
        end else begin
          win_d     = win_q + WIN_W'(1);
          cnt_d     = sum_cnt;
          cnt_ovf_d = sum_ovf;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      flush_q    <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      cnt_ovf_q  <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      stuck_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      cnt_ovf_q  <= cnt_ovf_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      stuck_q    <= stuck_d;
      ovf_q      <= ovf_d;
    end
  end

  assign COUNT    = count_q;
  assign VALID    = valid_q;
  assign IN_RANGE = in_range_q;
  assign STUCK    = stuck_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_osc_freq_monitor.sv
`timescale 1ns/1ps
// tb_osc_freq_monitor
// Drives a default monitor and a 4-bit-counter monitor from the same
// oscillator. Free-running async oscillators are checked against frequency
// ranges; randomized CLK-aligned oscillator patterns are checked exactly
// against a reference that counts rising transitions in the recorded
// sample history over each window.
module tb_osc_freq_monitor;

  localparam int WIN = 4000;
  localparam int LO  = 90;
  localparam int HI  = 110;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_clk = 1'b0;
  logic        en = 1'b0;
  logic [15:0] count;
  logic        valid, in_range, stuck, ovf;
  logic [3:0]  count4;
  logic        valid4, in_range4, stuck4, ovf4;

  int n_checks = 0;
  int n_pass   = 0;

  osc_freq_monitor u_dut (
    .CLK(clk), .RSTN(rstn), .CFGCLK(cfg_clk), .EN(en),
    .COUNT(count), .VALID(valid), .IN_RANGE(in_range), .STUCK(stuck), .OVF(ovf)
  );

  osc_freq_monitor #(.CNT_W(4)) u_dut4 (
    .CLK(clk), .RSTN(rstn), .CFGCLK(cfg_clk), .EN(en),
    .COUNT(count4), .VALID(valid4), .IN_RANGE(in_range4), .STUCK(stuck4), .OVF(ovf4)
  );

  always #5 clk = ~clk;

  // Sample history: samp[i] is the oscillator level at posedge i.
  int cyc = 0;
  bit samp[$];
  always @(posedge clk) begin
    samp.push_back(cfg_clk);
    cyc <= cyc + 1;
  end

  // Oscillator: 0 = held low, 1 = free-running async, 2 = random CLK-aligned.
  int      osc_mode = 0;
  realtime osc_half = 200.0;
  int      hi_min = 1, hi_max = 1, lo_min = 2, lo_max = 2;
  int      pat_gen = 0;
  int      seen_gen = 0;
  int      phase_left = 0;

  always begin
    if (osc_mode == 1) begin
      #(osc_half);
      if (osc_mode == 1) cfg_clk = ~cfg_clk;
    end else begin
      @(negedge clk);
      if (osc_mode == 0) begin
        cfg_clk = 1'b0;
      end else begin
        if (seen_gen != pat_gen) begin
          seen_gen   = pat_gen;
          phase_left = 0;
        end
        if (phase_left <= 1) begin
          cfg_clk    = ~cfg_clk;
          phase_left = cfg_clk ? int'($urandom_range(hi_max, hi_min))
                               : int'($urandom_range(lo_max, lo_min));
        end else begin
          phase_left = phase_left - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_valid(input int budget, output int at);
    int  i;
    logic seen;
    at   = -1;
    seen = 1'b0;
    i    = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        at   = cyc - 1;
      end
      i++;
    end
    if (!seen) check("valid_timeout", 32'(seen), 32'd1);
  endtask

  // Edges counted by the monitor: synchronized rises whose detection falls
  // inside the window; with two sync flops that is a sample-history rise at
  // index r in [e0+2+n*WIN, e0+2+(n+1)*WIN).
  function automatic int model_count(input int e0, input int n);
    int c = 0;
    int lo = e0 + 2 + n * WIN;
    for (int r = lo; r < lo + WIN; r++) begin
      if (samp[r-1] == 1'b0 && samp[r] == 1'b1) c++;
    end
    return c;
  endfunction

  int exp_last_count, exp_last_count4;
  bit exp_last_in_range, exp_last_stuck;

  task automatic check_window(input string tag, input int e0, input int n, input int at);
    int c;
    int c4;
    c  = model_count(e0, n);
    c4 = (c > 15) ? 15 : c;
    $display("window %s n=%0d at=%0d count=%0d count4=%0d model=%0d",
             tag, n, at, count, count4, c);
    check({tag, "_at"},        32'(at),        32'(e0 + 3 + (n + 1) * WIN));
    check({tag, "_count"},     32'(count),     32'(c));
    check({tag, "_in_range"},  32'(in_range),  32'(c >= LO && c <= HI));
    check({tag, "_stuck"},     32'(stuck),     32'(c == 0));
    check({tag, "_ovf"},       32'(ovf),       32'(c > 65535));
    check({tag, "_valid4"},    32'(valid4),    32'd1);
    check({tag, "_count4"},    32'(count4),    32'(c4));
    check({tag, "_ovf4"},      32'(ovf4),      32'(c > 15));
    check({tag, "_stuck4"},    32'(stuck4),    32'(c == 0));
    check({tag, "_in_range4"}, 32'(in_range4), 32'(c4 >= LO && c4 <= HI && c <= 15));
    exp_last_count    = c;
    exp_last_count4   = c4;
    exp_last_in_range = (c >= LO && c <= HI);
    exp_last_stuck    = (c == 0);
  endtask

  task automatic pick_pattern(input int sel);
    case (sel)
      0: begin hi_min = 1;  hi_max = 2;  lo_min = 2;  lo_max = 3;  osc_mode = 2; end
      1: begin hi_min = 18; hi_max = 22; lo_min = 18; lo_max = 22; osc_mode = 2; end
      2: begin hi_min = 1;  hi_max = 40; lo_min = 5;  lo_max = 80; osc_mode = 2; end
      default: osc_mode = 0;
    endcase
    pat_gen++;
  endtask

  initial begin
    int e0, at, prev, seen;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_count",    32'(count),    32'd0);
    check("rst_valid",    32'(valid),    32'd0);
    check("rst_in_range", 32'(in_range), 32'd0);
    check("rst_stuck",    32'(stuck),    32'd0);
    check("rst_ovf",      32'(ovf),      32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 2.5 MHz async oscillator
    osc_half = 200.0;
    osc_mode = 1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    e0 = cyc;
    wait_valid(4100, at);
    $display("osc 2.5MHz at=%0d count=%0d count4=%0d", at, count, count4);
    check("f25_latency",  32'(at - e0),  32'd4003);
    check("f25_count_rng", 32'(count >= 99 && count <= 101), 32'd1);
    check("f25_in_range", 32'(in_range), 32'd1);
    check("f25_stuck",    32'(stuck),    32'd0);
    check("f25_ovf",      32'(ovf),      32'd0);
    check("f25_count4",   32'(count4),   32'd15);
    check("f25_ovf4",     32'(ovf4),     32'd1);
    check("f25_in_range4", 32'(in_range4), 32'd0);
    @(negedge clk);
    check("f25_pulse",    32'(valid),    32'd0);

    // 5.4 MHz async oscillator, spacing between consecutive results
    osc_half = 92.59;
    wait_valid(4100, at);
    wait_valid(4100, at);
    prev = at;
    $display("osc 5.4MHz at=%0d count=%0d", at, count);
    check("f54_count_rng", 32'(count >= 215 && count <= 217), 32'd1);
    check("f54_in_range", 32'(in_range), 32'd0);
    check("f54_ovf",      32'(ovf),      32'd0);
    wait_valid(4100, at);
    $display("osc 5.4MHz at=%0d count=%0d", at, count);
    check("f54_spacing",  32'(at - prev), 32'd4000);
    check("f54_count_rng2", 32'(count >= 215 && count <= 217), 32'd1);

    // Randomized CLK-aligned patterns against the reference
    @(negedge clk);
    en = 1'b0;
    pick_pattern(int'($urandom_range(3, 0)));
    repeat (20) @(negedge clk);
    en = 1'b1;
    e0 = cyc;
    for (int n = 0; n < 3; n++) begin
      wait_valid(4100, at);
      check_window("rnd", e0, n, at);
      pick_pattern(int'($urandom_range(3, 0)));
    end

    // Oscillator held low, then back to a nominal pattern
    pick_pattern(3);
    for (int n = 3; n < 5; n++) begin
      wait_valid(4100, at);
      check_window("stuck", e0, n, at);
    end
    check("stuck_flag", 32'(stuck), 32'd1);
    pick_pattern(1);
    wait_valid(4100, at);
    check_window("nominal", e0, 5, at);

    // Abort mid-window: no result, outputs hold
    repeat (2000) @(negedge clk);
    en   = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid) seen++;
    end
    $display("abort count=%0d valid_pulses=%0d", count, seen);
    check("abort_no_valid",  32'(seen),     32'd0);
    check("abort_count",     32'(count),    32'(exp_last_count));
    check("abort_in_range",  32'(in_range), 32'(exp_last_in_range));
    check("abort_stuck",     32'(stuck),    32'(exp_last_stuck));
    check("abort_count4",    32'(count4),   32'(exp_last_count4));
    en = 1'b1;
    e0 = cyc;
    wait_valid(4100, at);
    check_window("rearm", e0, 0, at);

    // Asynchronous reset mid-window
    repeat (1500) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    $display("async reset count=%0d valid=%0d ovf4=%0d", count, valid, ovf4);
    check("arst_count",    32'(count),    32'd0);
    check("arst_valid",    32'(valid),    32'd0);
    check("arst_in_range", 32'(in_range), 32'd0);
    check("arst_stuck",    32'(stuck),    32'd0);
    check("arst_ovf",      32'(ovf),      32'd0);
    check("arst_count4",   32'(count4),   32'd0);
    check("arst_ovf4",     32'(ovf4),     32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    e0 = cyc;
    wait_valid(4100, at);
    check_window("post_rst", e0, 0, at);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
